// File: rtl/sfifo_param.sv
// sfifo_param: parametrised single-clock FIFO with level flags,
// sticky error flags, flush and optional first-word-fall-through.
module sfifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam cnt_t DEPTH_W = cnt_t'(DEPTH);
  localparam cnt_t AF_W    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_W    = cnt_t'(AE_THRESH);

  word_t mem [DEPTH];
  word_t ram_q;

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  fill_q, fill_d;
  cnt_t  ram_cnt_q, ram_cnt_d;
  logic  mid_v_q, mid_v_d;
  logic  ov_q, ov_d;
  word_t dout_q, dout_d;
  logic  ovf_q, ovf_d;
  logic  unf_q, unf_d;

  logic wr_acc, rd_acc;
  logic out_free, mid_mv, mid_free;
  logic ram_rd, mem_we, ram_re;

  assign full  = (fill_q == DEPTH_W);
  assign empty = FWFT ? ~ov_q : (fill_q == '0);

  assign almost_full  = (fill_q >= AF_W);
  assign almost_empty = (fill_q <= AE_W);
  assign fill_count   = fill_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign data_out     = FWFT ? dout_q : ram_q;

  // next-state for pointers, counts, output stage and error flags
  always_comb begin
    wr_acc   = wr_en & ~full;
    rd_acc   = rd_en & ~empty;
    out_free = 1'b0;
    mid_mv   = 1'b0;
    mid_free = 1'b0;
    ram_rd   = rd_acc;
    if (FWFT) begin
      out_free = ~ov_q | rd_acc;
      mid_mv   = mid_v_q & out_free;
      mid_free = ~mid_v_q | mid_mv;
      ram_rd   = (ram_cnt_q != '0) & mid_free;
    end

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    ram_cnt_d = ram_cnt_q;
    mid_v_d   = mid_v_q;
    ov_d      = ov_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    ram_re    = 1'b0;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      fill_d    = '0;
      ram_cnt_d = '0;
      mid_v_d   = 1'b0;
      ov_d      = 1'b0;
    end else begin
      mem_we = wr_acc & ~rst;
      ram_re = ram_rd & ~rst;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (ram_rd) rd_ptr_d = rd_ptr_q + 1'b1;

      case ({wr_acc, rd_acc})
        2'b10:   fill_d = fill_q + 1'b1;
        2'b01:   fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase

      case ({wr_acc, ram_rd})
        2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
        2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
        default: ram_cnt_d = ram_cnt_q;
      endcase

      if (FWFT) begin
        mid_v_d = ram_rd | (mid_v_q & ~mid_mv);
        ov_d    = mid_mv | (ov_q & ~rd_acc);
        if (mid_mv) dout_d = ram_q;
      end

      ovf_d = (ovf_q & ~clr_err) | (wr_en & full);
      unf_d = (unf_q & ~clr_err) | (rd_en & empty);
    end
  end

  // control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      ram_cnt_q <= '0;
      mid_v_q   <= 1'b0;
      ov_q      <= 1'b0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      ram_cnt_q <= ram_cnt_d;
      mid_v_q   <= mid_v_d;
      ov_q      <= ov_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= data_in;
  end

  // RAM synchronous read port; doubles as data_out in standard mode
  always_ff @(posedge clk) begin
    if (rst) ram_q <= '0;
    else if (ram_re) ram_q <= mem[rd_ptr_q];
  end

endmodule
